// File: rtl/fft_frame_unloader.sv
// Ping-pong frame buffer that turns a parallel FFT result into a stream.
// Words leave in bit-reversed or natural index order under valid/ready.
module fft_frame_unloader #(
  parameter int N_POINTS = 64,
  parameter int DATA_W   = 32,
  parameter bit BITREV   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_POINTS*DATA_W-1:0]   frame_in,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_POINTS)-1:0]  out_index,
  output logic                         out_last,
  output logic                         overflow
);

  localparam int IDX_W = $clog2(N_POINTS);
  localparam int FW    = N_POINTS * DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_POINTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  state_t           state_nx;
  logic [FW-1:0]    bank [2];
  logic [1:0]       full;
  logic             wsel;
  logic             rsel;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] phys;
  logic             cap;
  logic             xfer;
  logic             done;

  function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
    return r;
  endfunction

  assign frame_ready = !full[wsel];
  assign cap  = frame_valid && frame_ready;
  assign xfer = out_valid && out_ready;
  assign done = xfer && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Back-to-back frames only when the other bank was full before this edge
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (full[rsel]) state_nx = STREAM;
      STREAM:  if (done && !full[~rsel]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == STREAM);
    phys      = BITREV ? bit_rev(cnt) : cnt;
    out_data  = bank[rsel][DATA_W*phys +: DATA_W];
    out_index = phys;
    out_last  = out_valid && (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank[0]  <= '0;
      bank[1]  <= '0;
      full     <= '0;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap) begin
        bank[wsel] <= frame_in;
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (frame_valid && !frame_ready) overflow <= 1'b1;
      if (done) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
        cnt        <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
